// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_pkg
//  Brief    : Shared state encoding and default constants for the stopwatch
//             sequencing controller.
//  Revision : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Default counting resolution: 100 Hz gives 10 ms per tick.
    localparam int c_TICK_HZ_DEFAULT = 100;

    // Controller states. Encodings 5..7 are never entered and recover to IDLE.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STOP  = 3'd2,
        ST_LAP   = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

endpackage : stopwatch_pkg
`default_nettype wire

// File: rtl/stopwatch_lap_ctrl_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Brief    : Clock divider producing a one-cycle tick every DIV enabled
//             cycles. Holds its phase while disabled; zeroes on request.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_zero,
    output logic o_tick
);

    localparam int c_CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_div_cnt;

    // Divider counter: zeroed on request, advances and wraps while enabled,
    // otherwise holds so a resume keeps the existing tick phase.
    always_ff @(posedge clk) begin
        if (rst || i_zero) begin
            r_div_cnt <= '0;
        end else if (i_en) begin
            if (r_div_cnt == c_CNT_MAX) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    assign o_tick = i_en && (r_div_cnt == c_CNT_MAX);

endmodule : tick_gen
`default_nettype wire

// File: rtl/stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : stopwatch_lap_ctrl
//  Brief    : Stopwatch sequencing controller. Turns run/stop, clear and lap
//             pulses into tick enable, datapath clear and lap freeze/capture.
//  Revision : 1.0 - initial release
// ============================================================================
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int TICK_HZ        = c_TICK_HZ_DEFAULT,
    parameter int LAP_HOLD_TICKS = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_runstop,
    input  logic       i_clear,
    input  logic       i_lap,
    output logic       o_tick,
    output logic       o_clear,
    output logic       o_freeze,
    output logic       o_lap_capture,
    output logic       o_running,
    output logic [2:0] o_state
);

    localparam int c_DIV    = CLK_HZ / TICK_HZ;
    localparam int c_HOLD_W = (LAP_HOLD_TICKS > 1) ? $clog2(LAP_HOLD_TICKS + 1) : 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LAP_HOLD_TICKS);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_lap_entry;
    logic                w_tick;
    logic                w_div_en;
    logic                w_div_zero;
    logic                w_expire;
    logic                w_lap_entry;

    // Divider runs while counting, freezes in STOP, restarts from IDLE/CLEAR.
    assign w_div_en   = (r_state == ST_RUN) || (r_state == ST_LAP);
    assign w_div_zero = !w_div_en && (r_state != ST_STOP);

    tick_gen #(
        .DIV (c_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_div_en),
        .i_zero (w_div_zero),
        .o_tick (w_tick)
    );

    assign w_expire    = (LAP_HOLD_TICKS != 0) && (r_hold_cnt == c_HOLD_MAX);
    assign w_lap_entry = (w_next_state == ST_LAP) && (r_state != ST_LAP);

    // State register plus the registered LAP-entry flag that drives capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_lap_entry <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_lap_entry <= w_lap_entry;
        end
    end

    // Lap hold counter: restarts on each LAP entry, counts ticks spent in LAP
    // and saturates at the hold limit.
    always_ff @(posedge clk) begin
        if (rst || w_lap_entry) begin
            r_hold_cnt <= '0;
        end else if ((r_state == ST_LAP) && w_tick && (r_hold_cnt != c_HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // Next-state decode with runstop > lap > clear priority, and register-only
    // output decode.
    always_comb begin
        w_next_state  = r_state;
        o_tick        = w_tick;
        o_clear       = (r_state == ST_CLEAR);
        o_freeze      = (r_state == ST_LAP);
        o_running     = w_div_en;
        o_lap_capture = r_lap_entry;
        o_state       = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_runstop) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (i_runstop)  w_next_state = ST_STOP;
                else if (i_lap) w_next_state = ST_LAP;
            end
            ST_LAP: begin
                if (i_runstop)              w_next_state = ST_STOP;
                else if (i_lap || w_expire) w_next_state = ST_RUN;
            end
            ST_STOP: begin
                if (i_runstop)    w_next_state = ST_RUN;
                else if (i_clear) w_next_state = ST_CLEAR;
            end
            ST_CLEAR: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

endmodule : stopwatch_lap_ctrl
`default_nettype wire

// File: tb/tb_stopwatch_lap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stopwatch_lap_ctrl
//  Brief    : Directed self-checking bench for stopwatch_lap_ctrl with
//             DIV = 10 and a 3-tick lap hold.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_lap_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_runstop = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_lap = 1'b0;
    logic       o_tick;
    logic       o_clear;
    logic       o_freeze;
    logic       o_lap_capture;
    logic       o_running;
    logic [2:0] o_state;

    int n_checks = 0;
    int n_pass   = 0;

    stopwatch_lap_ctrl #(
        .CLK_HZ         (1000),
        .TICK_HZ        (100),
        .LAP_HOLD_TICKS (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_runstop     (i_runstop),
        .i_clear       (i_clear),
        .i_lap         (i_lap),
        .o_tick        (o_tick),
        .o_clear       (o_clear),
        .o_freeze      (o_freeze),
        .o_lap_capture (o_lap_capture),
        .o_running     (o_running),
        .o_state       (o_state)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // One-cycle input pulse; returns in the first cycle showing the new state.
    task automatic pulse(input bit rs, input bit lp, input bit cl);
        i_runstop = rs;
        i_lap     = lp;
        i_clear   = cl;
        step(1);
        i_runstop = 1'b0;
        i_lap     = 1'b0;
        i_clear   = 1'b0;
    endtask

    // Cycles from the last pulse cycle to the first tick (bounded at 40).
    task automatic wait_tick(output int cyc);
        cyc = 1;
        while (!o_tick && cyc < 40) begin
            step(1);
            cyc++;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_state"},   o_state,       0);
        chk({tag, "_tick"},    o_tick,        0);
        chk({tag, "_clear"},   o_clear,       0);
        chk({tag, "_freeze"},  o_freeze,      0);
        chk({tag, "_capture"}, o_lap_capture, 0);
        chk({tag, "_running"}, o_running,     0);
    endtask

    initial begin
        int cyc;
        int ticks;
        int lap_cycles;

        // Reset state
        rst = 1'b1;
        step(2);
        chk_idle_outputs("reset");
        rst = 1'b0;

        // Start from cycle 0: RUN in cycle 1, ticks in cycles 10, 20, 30
        pulse(1, 0, 0);
        chk("start_state", o_state, 1);
        chk("start_running", o_running, 1);
        for (int c = 1; c <= 30; c++) begin
            chk($sformatf("tick_c%0d", c), o_tick, (c % 10 == 0) ? 1 : 0);
            step(1);
        end

        // Cycle 31 has div_cnt 0; move to div_cnt 4 and stop
        step(4);
        pulse(1, 0, 0);
        chk("stop_state", o_state, 2);
        chk("stop_running", o_running, 0);
        ticks = 0;
        for (int k = 0; k < 50; k++) begin
            if (o_tick) ticks++;
            step(1);
        end
        chk("stop_no_ticks", ticks, 0);
        pulse(1, 0, 0);
        chk("resume_state", o_state, 1);
        wait_tick(cyc);
        chk("resume_first_tick", cyc, 5);

        // Lap with auto-release after 3 ticks (entry with div_cnt 1)
        step(1);
        pulse(0, 1, 0);
        chk("lap_state", o_state, 3);
        chk("lap_capture", o_lap_capture, 1);
        chk("lap_freeze", o_freeze, 1);
        chk("lap_running", o_running, 1);
        step(1);
        chk("lap_capture_once", o_lap_capture, 0);
        chk("lap_freeze_hold", o_freeze, 1);
        lap_cycles = 1;
        ticks = 0;
        while (o_freeze && lap_cycles < 100) begin
            if (o_tick) ticks++;
            lap_cycles++;
            step(1);
        end
        chk("lap_ticks", ticks, 3);
        chk("lap_cycles", lap_cycles, 30);
        chk("lap_release_state", o_state, 1);
        chk("lap_release_freeze", o_freeze, 0);

        // Lap again (div_cnt 1), released by lap after one tick
        pulse(0, 1, 0);
        chk("lap2_capture", o_lap_capture, 1);
        wait_tick(cyc);
        chk("lap2_first_tick", cyc, 8);
        chk("lap2_freeze", o_freeze, 1);
        step(1);
        pulse(0, 1, 0);
        chk("lap2_manual_state", o_state, 1);
        chk("lap2_manual_freeze", o_freeze, 0);
        chk("lap2_manual_capture", o_lap_capture, 0);

        // Stop on the tick cycle: divider wraps, resume needs a full DIV
        wait_tick(cyc);
        chk("pre_wrap_tick", cyc, 9);
        pulse(1, 0, 0);
        chk("wrap_stop_state", o_state, 2);
        pulse(1, 0, 0);
        wait_tick(cyc);
        chk("wrap_resume_tick", cyc, 10);

        // Priority in STOP, then clear alone
        step(1);
        pulse(1, 0, 0);
        pulse(1, 1, 1);
        chk("prio_state", o_state, 1);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        chk("clear_state", o_state, 4);
        chk("clear_strobe", o_clear, 1);
        chk("clear_running", o_running, 0);
        step(1);
        chk("clear_to_idle", o_state, 0);
        chk("clear_once", o_clear, 0);

        // Ignored inputs
        pulse(0, 0, 1);
        chk("idle_clear_state", o_state, 0);
        chk("idle_clear_strobe", o_clear, 0);
        pulse(0, 1, 0);
        chk("idle_lap_state", o_state, 0);
        chk("idle_lap_capture", o_lap_capture, 0);
        pulse(1, 0, 0);
        wait_tick(cyc);
        chk("after_clear_tick", cyc, 10);
        pulse(0, 0, 1);
        chk("run_clear_state", o_state, 1);
        chk("run_clear_strobe", o_clear, 0);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("stop_lap_state", o_state, 2);
        chk("stop_lap_capture", o_lap_capture, 0);
        chk("stop_lap_freeze", o_freeze, 0);

        // Reset in LAP with div_cnt 7
        pulse(1, 0, 0);
        wait_tick(cyc);
        chk("align_tick", o_tick, 1);
        pulse(0, 1, 0);
        step(7);
        chk("prerst_state", o_state, 3);
        chk("prerst_freeze", o_freeze, 1);
        rst = 1'b1;
        step(1);
        chk_idle_outputs("midlap_rst");
        rst = 1'b0;
        pulse(1, 0, 0);
        wait_tick(cyc);
        chk("rst_restart_tick", cyc, 10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_stopwatch_lap_ctrl
`default_nettype wire
